// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle signed/unsigned multiply and restoring divide unit
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             annul_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW       = $clog2(WIDTH);
  localparam int LAST_MUL = (MUL_STAGES > 1) ? MUL_STAGES - 2 : 0;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] divisor, quo, rem;
  logic             q_neg, r_neg;

  logic               accept, is_signed, is_div, a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod_now, mul_res;
  logic [WIDTH:0]     rem_shift, diff;
  logic [WIDTH-1:0]   q_next, r_next;

  assign accept    = start_i & ready_o & ~annul_i;
  assign is_signed = ~op_i[0];
  assign is_div    = op_i[1];
  assign a_neg     = is_signed & a_i[WIDTH-1];
  assign b_neg     = is_signed & b_i[WIDTH-1];
  assign mag_a     = a_neg ? -a_i : a_i;
  assign mag_b     = b_neg ? -b_i : b_i;
  assign ext_a     = {{WIDTH{a_neg}}, a_i};
  assign ext_b     = {{WIDTH{b_neg}}, b_i};
  assign prod_now  = ext_a * ext_b;
  assign busy_o    = ~ready_o;

  // Restoring step: keep the shifted remainder whenever the trial subtract borrows
  assign rem_shift = {rem, quo[WIDTH-1]};
  assign diff      = rem_shift - {1'b0, divisor};
  assign q_next    = {quo[WIDTH-2:0], ~diff[WIDTH]};
  assign r_next    = diff[WIDTH] ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];

  // The hi/lo register is the last product stage, so the pipe holds MUL_STAGES-1 entries
  generate
    if (MUL_STAGES > 1) begin : g_mul_pipe
      logic [2*WIDTH-1:0] pipe [MUL_STAGES-1];
      always_ff @(posedge clk) begin
        pipe[0] <= prod_now;
        for (int i = 1; i < MUL_STAGES - 1; i++) pipe[i] <= pipe[i-1];
      end
      assign mul_res = pipe[MUL_STAGES-2];
    end else begin : g_mul_direct
      assign mul_res = prod_now;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      hi_o    <= '0;
      lo_o    <= '0;
      cnt     <= '0;
      divisor <= '0;
      quo     <= '0;
      rem     <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          cnt     <= '0;
          divisor <= mag_b;
          quo     <= mag_a;
          rem     <= '0;
          q_neg   <= a_neg ^ b_neg;
          r_neg   <= a_neg;
          ready_o <= 1'b0;
          if (!is_div) begin
            if (MUL_STAGES == 1) begin
              {hi_o, lo_o} <= mul_res;
              valid_o      <= 1'b1;
              state        <= DONE;
            end else begin
              state <= MUL;
            end
          end else if (b_i == '0) begin
            hi_o    <= a_i;
            lo_o    <= '1;
            valid_o <= 1'b1;
            state   <= DONE;
          end else begin
            state <= DIV;
          end
        end
        MUL: if (annul_i) begin
          state   <= IDLE;
          ready_o <= 1'b1;
        end else if (cnt == CW'(LAST_MUL)) begin
          {hi_o, lo_o} <= mul_res;
          valid_o      <= 1'b1;
          state        <= DONE;
        end else begin
          cnt <= cnt + CW'(1);
        end
        DIV: if (annul_i) begin
          state   <= IDLE;
          ready_o <= 1'b1;
        end else begin
          quo <= q_next;
          rem <= r_next;
          if (cnt == CW'(WIDTH - 1)) begin
            hi_o    <= r_neg ? -r_next : r_next;
            lo_o    <= q_neg ? -q_next : q_next;
            valid_o <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state   <= IDLE;
          ready_o <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_o <= 1'b1;
        end
      endcase
    end
  end
endmodule
